multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Control FSM that sequences the multicycle CPU datapath: PC, IR, register file, extender, ALU and data memory.
- Consumes the IR opcode and the ALU zero flag; produces every datapath enable/select plus the current state.
- Instantiated inside CPU between the IR and the datapath muxes.
- Replaces any ad-hoc per-instruction decoding in the top level.

Parameters:
HALT_ON_ILLEGAL, 0, 1 = an undefined opcode halts like halt; 0 = it executes as a nop.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]; valid from ID onward
zero  in  1  ALU zero flag
PCWre  out  1  PC write enable
IRWre  out  1  IR write enable
ALUSrcB  out  1  0 = ReadData2, 1 = ExtDataOut
ALUM2Reg  out  1  0 = ALU result, 1 = memory data
RegWre  out  1  register file write enable
WrRegData  out  1  0 = PC4 (jal), 1 = ALUM2DRData
DataMemRW  out  1  0 = read, 1 = write
ExtSel  out  2  00 = zero-extend shamt, 01 = zero-extend imm16, 10 = sign-extend imm16
PCSrc  out  2  00 = PC4, 01 = branch target, 10 = rs (jr), 11 = jump target
RegOut  out  2  00 = $31, 01 = rt, 10 = rd
ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt
state  out  3  current FSM state
halted  out  1  1 while parked on halt
illegal  out  1  one-cycle pulse in ID on an undefined opcode

Behaviour:
- Opcodes:
  - ALU class: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110.
  - Memory: sw 110000, lw 110001.
  - Control flow: beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
- States: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- State register is the only storage; all other outputs are combinational from state, opcode and zero.
- Reset:
  - state <= IF on the clock edge with reset high.
  - While reset is high, PCWre, IRWre, RegWre and DataMemRW are forced to 0.
  - Other selects are 0 during reset; halted = 0, illegal = 0.
- Reset mid-instruction aborts the instruction: no register or memory write at that edge.
- IF: IRWre = 1; all other enables 0; outputs independent of opcode (opcode is stale). Next state: ID.
- ID: next state by opcode class.
  - j: PCWre = 1, PCSrc = 11 -> IF.
  - jr: PCWre = 1, PCSrc = 10 -> IF.
  - jal: PCWre = 1, PCSrc = 11, RegWre = 1, RegOut = 00, WrRegData = 0 -> IF.
  - halt: stay in ID. PCWre = IRWre = 0, halted = 1; leaves only via reset.
  - beq -> EXE_BR; lw/sw -> EXE_LS; ALU class -> EXE_AL.
  - Undefined opcode: illegal = 1. If HALT_ON_ILLEGAL = 0, behaves as a nop: PCWre = 1, PCSrc = 00 -> IF. Otherwise behaves as halt.
- EXE_AL: ALUSrcB = 1 for addi/ori, 0 otherwise.
  - ExtSel = 00 for sll, 01 for ori, 10 for addi.
  - ALUOp per opcode (addi = add, ori = or). Next state: WB_AL.
- WB_AL: selects held from EXE_AL; RegWre = 1, WrRegData = 1, ALUM2Reg = 0.
  - RegOut = 01 for addi/ori, 10 for R-type.
  - PCWre = 1, PCSrc = 00 -> IF.
- EXE_BR: ALUSrcB = 0, ALUOp = 001, ExtSel = 10, PCWre = 1, PCSrc = zero ? 01 : 00 -> IF.
- EXE_LS: ALUSrcB = 1, ExtSel = 10, ALUOp = 000 -> MEM.
- MEM: address selects held from EXE_LS.
  - sw: DataMemRW = 1, PCWre = 1, PCSrc = 00 -> IF.
  - lw: DataMemRW = 0 -> WB_LD.
- WB_LD: ALUM2Reg = 1, WrRegData = 1, RegOut = 01, RegWre = 1, PCWre = 1, PCSrc = 00 -> IF.
- Instruction latencies: j/jr/jal = 2 cycles; beq = 3; ALU class and sw = 4; lw = 5.
- At most one of RegWre and DataMemRW is high in any cycle.
- PCWre is high exactly once per completed instruction.

Decomposition:
- Package mcpu_pkg holds:
  - opcode constants;
  - state encodings;
  - ALUOp, PCSrc, RegOut and ExtSel encodings.
- One sub-module: mcpu_op_class, a combinational opcode -> {alu, imm, branch, ls, jump, halt, illegal} decoder shared with the disassembler monitor.

Test Plan:
- Reset held 2 cycles, then released with opcode = add -> state sequence 000,001,110,111,000; RegWre = 1 and RegOut = 10 only in state 111; PCWre = 1 only in 111.
- lw (110001) -> states 000,001,010,011,100; DataMemRW = 0 throughout; RegWre, ALUM2Reg and PCWre = 1 only in state 100.
- sw (110000) -> states 000,001,010,011; DataMemRW = 1 only in 011; RegWre never 1.
- beq with zero = 1 -> PCSrc = 01 in EXE_BR; repeat with zero = 0 -> PCSrc = 00; both take 3 cycles.
- jal -> in ID: RegWre = 1, RegOut = 00, WrRegData = 0, PCSrc = 11, PCWre = 1; back in IF next cycle.
- halt (111111) -> state stays 001 for 20 cycles with halted = 1 and PCWre = 0.
  - Reset then returns state to 000.
  - Opcode 101010 with HALT_ON_ILLEGAL = 0 -> illegal pulses one cycle and the next state is IF.

Source files
------------

// File: rtl/mcpu_pkg.sv
// mcpu_pkg: opcodes, FSM states and datapath select encodings for the multicycle CPU controller.
// Rev 1.0
`default_nettype none

package mcpu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] REG_RA = 2'b00;
  localparam logic [1:0] REG_RT = 2'b01;
  localparam logic [1:0] REG_RD = 2'b10;

  localparam logic [1:0] EXT_SHAMT = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_SIGN  = 2'b10;

  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    case (op)
      OP_SUB:        return ALU_SUB;
      OP_SLL:        return ALU_SLL;
      OP_OR, OP_ORI: return ALU_OR;
      OP_AND:        return ALU_AND;
      OP_SLT:        return ALU_SLT;
      default:       return ALU_ADD;
    endcase
  endfunction

  // R-type ops other than sll never look at the extender, so they share the shamt code.
  function automatic logic [1:0] ext_sel_of(input logic [5:0] op);
    case (op)
      OP_ORI:  return EXT_ZERO;
      OP_ADDI: return EXT_SIGN;
      default: return EXT_SHAMT;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mcpu_op_class.sv
// mcpu_op_class: combinational opcode classifier shared by the controller and the disassembler monitor.
// Rev 1.0
`default_nettype none

module mcpu_op_class
  import mcpu_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic       alu_o,
  output logic       imm_o,
  output logic       branch_o,
  output logic       ls_o,
  output logic       jump_o,
  output logic       halt_o,
  output logic       illegal_o
);

  always_comb begin
    alu_o     = 1'b0;
    imm_o     = 1'b0;
    branch_o  = 1'b0;
    ls_o      = 1'b0;
    jump_o    = 1'b0;
    halt_o    = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT: alu_o = 1'b1;
      OP_ADDI, OP_ORI: begin
        alu_o = 1'b1;
        imm_o = 1'b1;
      end
      OP_SW, OP_LW:        ls_o     = 1'b1;
      OP_BEQ:              branch_o = 1'b1;
      OP_J, OP_JR, OP_JAL: jump_o   = 1'b1;
      OP_HALT:             halt_o   = 1'b1;
      default:             illegal_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: control FSM sequencing PC, IR, register file, extender, ALU and data memory.
// Rev 1.0
`default_nettype none

module multicycle_control_unit
  import mcpu_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       ALUSrcB,
  output logic       ALUM2Reg,
  output logic       RegWre,
  output logic       WrRegData,
  output logic       DataMemRW,
  output logic [1:0] ExtSel,
  output logic [1:0] PCSrc,
  output logic [1:0] RegOut,
  output logic [2:0] ALUOp,
  output logic [2:0] state,
  output logic       halted,
  output logic       illegal
);

  state_e state_q, state_d;
  logic   w_alu, w_imm, w_branch, w_ls, w_jump, w_halt, w_illegal;

  mcpu_op_class u_op_class (
    .opcode_i  (opcode),
    .alu_o     (w_alu),
    .imm_o     (w_imm),
    .branch_o  (w_branch),
    .ls_o      (w_ls),
    .jump_o    (w_jump),
    .halt_o    (w_halt),
    .illegal_o (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d   = state_q;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    ALUSrcB   = 1'b0;
    ALUM2Reg  = 1'b0;
    RegWre    = 1'b0;
    WrRegData = 1'b0;
    DataMemRW = 1'b0;
    ExtSel    = EXT_SHAMT;
    PCSrc     = PC_NEXT;
    RegOut    = REG_RA;
    ALUOp     = ALU_ADD;
    halted    = 1'b0;
    illegal   = 1'b0;
    // Reset gates every output so an in-flight instruction cannot commit on the reset edge.
    if (!reset) begin
      case (state_q)
        S_IF: begin
          IRWre   = 1'b1;
          state_d = S_ID;
        end
        S_ID: begin
          if (w_jump) begin
            PCWre   = 1'b1;
            PCSrc   = (opcode == OP_JR) ? PC_REG : PC_JUMP;
            state_d = S_IF;
            if (opcode == OP_JAL) begin
              RegWre = 1'b1;
              RegOut = REG_RA;
            end
          end else if (w_halt || (w_illegal && HALT_ON_ILLEGAL)) begin
            halted  = 1'b1;
            illegal = w_illegal;
          end else if (w_illegal) begin
            illegal = 1'b1;
            PCWre   = 1'b1;
            state_d = S_IF;
          end else if (w_branch) begin
            state_d = S_EXE_BR;
          end else if (w_ls) begin
            state_d = S_EXE_LS;
          end else if (w_alu) begin
            state_d = S_EXE_AL;
          end
        end
        S_EXE_AL, S_WB_AL: begin
          ALUSrcB = w_imm;
          ExtSel  = ext_sel_of(opcode);
          ALUOp   = alu_op_of(opcode);
          if (state_q == S_EXE_AL) begin
            state_d = S_WB_AL;
          end else begin
            RegWre    = 1'b1;
            WrRegData = 1'b1;
            RegOut    = w_imm ? REG_RT : REG_RD;
            PCWre     = 1'b1;
            state_d   = S_IF;
          end
        end
        S_EXE_BR: begin
          ALUOp   = ALU_SUB;
          ExtSel  = EXT_SIGN;
          PCWre   = 1'b1;
          PCSrc   = zero ? PC_BRANCH : PC_NEXT;
          state_d = S_IF;
        end
        S_EXE_LS, S_MEM: begin
          ALUSrcB = 1'b1;
          ExtSel  = EXT_SIGN;
          ALUOp   = ALU_ADD;
          if (state_q == S_EXE_LS) begin
            state_d = S_MEM;
          end else if (opcode == OP_SW) begin
            DataMemRW = 1'b1;
            PCWre     = 1'b1;
            state_d   = S_IF;
          end else begin
            state_d = S_WB_LD;
          end
        end
        S_WB_LD: begin
          ALUM2Reg  = 1'b1;
          WrRegData = 1'b1;
          RegOut    = REG_RT;
          RegWre    = 1'b1;
          PCWre     = 1'b1;
          state_d   = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed stimulus, per-cycle reference model compare plus literal sequence checks.
// Rev 1.0
`default_nettype none

module tb_multicycle_control_unit;

  localparam logic [5:0] C_ADD = 6'b000000, C_SUB = 6'b000001, C_ADDI = 6'b000010;
  localparam logic [5:0] C_OR = 6'b010000, C_AND = 6'b010001, C_ORI = 6'b010010;
  localparam logic [5:0] C_SLL = 6'b011000, C_SLT = 6'b100110, C_SW = 6'b110000;
  localparam logic [5:0] C_LW = 6'b110001, C_BEQ = 6'b110100, C_J = 6'b111000;
  localparam logic [5:0] C_JR = 6'b111001, C_JAL = 6'b111010, C_HALT = 6'b111111;
  localparam logic [5:0] C_UNDEF = 6'b101010;

  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4;
  localparam int K_JR = 5, K_JAL = 6, K_HALT = 7, K_ILL = 8;

  typedef struct packed {
    logic       pcwre, irwre, srcb, m2reg, regwre, wrdata, memrw;
    logic [1:0] ext, pcsrc, regout;
    logic [2:0] aluop, st;
    logic       halted, illegal;
  } exp_t;

  logic       clk, reset, zero;
  logic [5:0] opcode;
  logic       PCWre, IRWre, ALUSrcB, ALUM2Reg, RegWre, WrRegData, DataMemRW;
  logic [1:0] ExtSel, PCSrc, RegOut;
  logic [2:0] ALUOp, state;
  logic       halted, illegal;

  int   checks = 0;
  int   failures = 0;
  int   m_step = 0;
  bit   model_on = 1'b0;
  logic [1:0] last_pcsrc, last_regout;
  logic       last_wrdata, last_illegal;

  multicycle_control_unit #(.HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg),
    .RegWre(RegWre), .WrRegData(WrRegData), .DataMemRW(DataMemRW),
    .ExtSel(ExtSel), .PCSrc(PCSrc), .RegOut(RegOut), .ALUOp(ALUOp),
    .state(state), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cls_of(input logic [5:0] op);
    case (op)
      C_ADD, C_SUB, C_ADDI, C_OR, C_AND, C_ORI, C_SLL, C_SLT: return K_ALU;
      C_LW:   return K_LW;
      C_SW:   return K_SW;
      C_BEQ:  return K_BEQ;
      C_J:    return K_J;
      C_JR:   return K_JR;
      C_JAL:  return K_JAL;
      C_HALT: return K_HALT;
      default: return K_ILL;
    endcase
  endfunction

  function automatic int latency(input int c);
    case (c)
      K_BEQ:        return 3;
      K_ALU, K_SW:  return 4;
      K_LW:         return 5;
      default:      return 2;
    endcase
  endfunction

  function automatic logic [2:0] alu_ref(input logic [5:0] op);
    case (op)
      C_SUB:        return 3'd1;
      C_SLL:        return 3'd2;
      C_OR, C_ORI:  return 3'd3;
      C_AND:        return 3'd4;
      C_SLT:        return 3'd5;
      default:      return 3'd0;
    endcase
  endfunction

  // Expected outputs for cycle 'step' of an instruction; anything the rules do not raise is 0.
  function automatic exp_t model(input logic [5:0] op, input logic z, input int step, input logic rst);
    exp_t e;
    int   c;
    logic imm;
    e   = '0;
    c   = cls_of(op);
    imm = (op == C_ADDI) || (op == C_ORI);
    if (step < 2)         e.st = step[2:0];
    else if (c == K_ALU)  e.st = (step == 2) ? 3'd6 : 3'd7;
    else if (c == K_BEQ)  e.st = 3'd5;
    else                  e.st = step[2:0];
    if (rst) return e;
    if (step == 0) begin
      e.irwre = 1'b1;
    end else if (step == 1) begin
      case (c)
        K_J:    begin e.pcwre = 1'b1; e.pcsrc = 2'b11; end
        K_JR:   begin e.pcwre = 1'b1; e.pcsrc = 2'b10; end
        K_JAL:  begin e.pcwre = 1'b1; e.pcsrc = 2'b11; e.regwre = 1'b1; end
        K_HALT: e.halted = 1'b1;
        K_ILL:  begin e.illegal = 1'b1; e.pcwre = 1'b1; end
        default: ;
      endcase
    end else if (c == K_ALU) begin
      e.srcb  = imm;
      e.aluop = alu_ref(op);
      e.ext   = (op == C_ORI) ? 2'b01 : (op == C_ADDI) ? 2'b10 : 2'b00;
      if (step == 3) begin
        e.regwre = 1'b1; e.wrdata = 1'b1; e.pcwre = 1'b1;
        e.regout = imm ? 2'b01 : 2'b10;
      end
    end else if (c == K_BEQ) begin
      e.aluop = 3'd1; e.ext = 2'b10; e.pcwre = 1'b1;
      e.pcsrc = z ? 2'b01 : 2'b00;
    end else if (c == K_LW || c == K_SW) begin
      if (step <= 3) begin e.srcb = 1'b1; e.ext = 2'b10; end
      if (step == 3 && c == K_SW) begin e.memrw = 1'b1; e.pcwre = 1'b1; end
      if (step == 4) begin
        e.m2reg = 1'b1; e.wrdata = 1'b1; e.regout = 2'b01; e.regwre = 1'b1; e.pcwre = 1'b1;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset)                                       m_step <= 0;
    else if (m_step == 1 && cls_of(opcode) == K_HALT) m_step <= 1;
    else if (m_step + 1 >= latency(cls_of(opcode)))  m_step <= 0;
    else                                             m_step <= m_step + 1;
  end

  always @(negedge clk) begin
    exp_t e, g;
    if (model_on) begin
      e = model(opcode, zero, m_step, reset);
      g = {PCWre, IRWre, ALUSrcB, ALUM2Reg, RegWre, WrRegData, DataMemRW,
           ExtSel, PCSrc, RegOut, ALUOp, state, halted, illegal};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL model_cycle t=%0t op=%b step=%0d got=%h exp=%h", $time, opcode, m_step, g, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Entered one time unit after the edge that puts the FSM in IF.
  task automatic do_instr(input string nm, input logic [5:0] op, input logic z, input int n,
                          input logic [14:0] es, input logic [4:0] ep, input logic [4:0] er,
                          input logic [4:0] em);
    logic [14:0] gs;
    logic [4:0]  gp, gr, gm;
    gs = '0; gp = '0; gr = '0; gm = '0;
    opcode = op;
    zero   = z;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gs = {gs[11:0], state};
      gp = {gp[3:0], PCWre};
      gr = {gr[3:0], RegWre};
      gm = {gm[3:0], DataMemRW};
      last_pcsrc   = PCSrc;
      last_regout  = RegOut;
      last_wrdata  = WrRegData;
      last_illegal = illegal;
      @(posedge clk);
      #1;
    end
    chk({nm, "_states"}, 32'(gs), 32'(es));
    chk({nm, "_pcwre"},  32'(gp), 32'(ep));
    chk({nm, "_regwre"}, 32'(gr), 32'(er));
    chk({nm, "_memrw"},  32'(gm), 32'(em));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    bit ok;
    reset  = 1'b1;
    opcode = C_ADD;
    zero   = 1'b0;
    @(posedge clk); #1;
    model_on = 1'b1;
    @(posedge clk); #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_irwre", 32'(IRWre), 32'd0);
    reset = 1'b0;

    do_instr("add",   C_ADD,  1'b0, 4, 15'b000001110111,    5'b00001, 5'b00001, 5'b00000);
    do_instr("lw",    C_LW,   1'b0, 5, 15'b000001010011100, 5'b00001, 5'b00001, 5'b00000);
    do_instr("sw",    C_SW,   1'b0, 4, 15'b000001010011,    5'b00001, 5'b00000, 5'b00001);
    do_instr("beq_t", C_BEQ,  1'b1, 3, 15'b000001101,       5'b00001, 5'b00000, 5'b00000);
    chk("beq_t_pcsrc", 32'(last_pcsrc), 32'd1);
    do_instr("beq_f", C_BEQ,  1'b0, 3, 15'b000001101,       5'b00001, 5'b00000, 5'b00000);
    chk("beq_f_pcsrc", 32'(last_pcsrc), 32'd0);
    do_instr("jal",   C_JAL,  1'b0, 2, 15'b000001,          5'b00001, 5'b00001, 5'b00000);
    chk("jal_regout", 32'(last_regout), 32'd0);
    chk("jal_pcsrc",  32'(last_pcsrc),  32'd3);
    chk("jal_wrdata", 32'(last_wrdata), 32'd0);
    do_instr("sub",   C_SUB,  1'b1, 4, 15'b000001110111,    5'b00001, 5'b00001, 5'b00000);
    do_instr("addi",  C_ADDI, 1'b0, 4, 15'b000001110111,    5'b00001, 5'b00001, 5'b00000);
    do_instr("ori",   C_ORI,  1'b0, 4, 15'b000001110111,    5'b00001, 5'b00001, 5'b00000);
    do_instr("sll",   C_SLL,  1'b0, 4, 15'b000001110111,    5'b00001, 5'b00001, 5'b00000);
    do_instr("slt",   C_SLT,  1'b0, 4, 15'b000001110111,    5'b00001, 5'b00001, 5'b00000);
    do_instr("or",    C_OR,   1'b0, 4, 15'b000001110111,    5'b00001, 5'b00001, 5'b00000);
    do_instr("and",   C_AND,  1'b0, 4, 15'b000001110111,    5'b00001, 5'b00001, 5'b00000);
    do_instr("j",     C_J,    1'b0, 2, 15'b000001,          5'b00001, 5'b00000, 5'b00000);
    do_instr("jr",    C_JR,   1'b0, 2, 15'b000001,          5'b00001, 5'b00000, 5'b00000);
    chk("jr_pcsrc", 32'(last_pcsrc), 32'd2);
    do_instr("lw_z",  C_LW,   1'b1, 5, 15'b000001010011100, 5'b00001, 5'b00001, 5'b00000);

    // Reset arriving while a store sits in MEM must suppress the write.
    opcode = C_SW;
    zero   = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", 32'(state),     32'd3);
    chk("abort_memrw", 32'(DataMemRW), 32'd0);
    chk("abort_pcwre", 32'(PCWre),     32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_to_if", 32'(state), 32'd0);

    opcode = C_HALT;
    @(posedge clk); #1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state !== 3'd1 || halted !== 1'b1 || PCWre !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("halt_park", 32'(ok), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("halt_reset_state", 32'(state), 32'd0);
    reset = 1'b0;

    do_instr("undef", C_UNDEF, 1'b0, 2, 15'b000001,         5'b00001, 5'b00000, 5'b00000);
    chk("undef_illegal", 32'(last_illegal), 32'd1);
    do_instr("add2",  C_ADD,  1'b0, 4, 15'b000001110111,    5'b00001, 5'b00001, 5'b00000);

    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
